dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 20 ++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants for the two-master data-memory arbiter
package dmem_arb_pkg;

  localparam int unsigned RAM_SIZE_DEFAULT = 256;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // A command may touch memory only when word aligned and inside the RAM.
  function automatic logic cmd_valid(input logic [31:0] addr, input logic [31:0] ram_size);
    return (addr[1:0] == 2'b00) && (addr < ram_size);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel
);

  // On a tie the master that was not served last wins.
  always_comb begin
    sel = M0;
    if (req == 2'b10) begin
      sel = M1;
    end else if (req == 2'b11) begin
      sel = (last == M0) ? M1 : M0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master data-memory arbiter, one transaction per two cycles
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned RAM_SIZE = RAM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic [0:0]  state;
  logic        last;
  logic        cur;
  logic        cur_wr;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        pick;
  logic        cur_valid;

  rr_arb2 u_rr_arb2 (
    .req  ({m1_req, m0_req}),
    .last (last),
    .sel  (pick)
  );

  assign cur_valid = cmd_valid(cur_addr, 32'(RAM_SIZE));

  // Strobes are combinational from state so an async reset in ACCESS drops them before the commit edge.
  assign mem_addr  = cur_addr;
  assign mem_wdata = cur_wdata;
  assign mem_rd    = (state == ST_ACCESS) && cur_valid && !cur_wr;
  assign mem_wr    = (state == ST_ACCESS) && cur_valid &&  cur_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      last      <= M1;
      cur       <= M0;
      cur_wr    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            cur       <= pick;
            last      <= pick;
            cur_wr    <= (pick == M1) ? m1_wr    : m0_wr;
            cur_addr  <= (pick == M1) ? m1_addr  : m0_addr;
            cur_wdata <= (pick == M1) ? m1_wdata : m0_wdata;
            m0_gnt    <= (pick == M0);
            m1_gnt    <= (pick == M1);
            state     <= ST_ACCESS;
          end
        end
        default: begin
          if (mem_rd) begin
            if (cur == M0) begin
              m0_rdata <= mem_rdata;
            end else begin
              m1_rdata <= mem_rdata;
            end
          end
          m0_done <= (cur == M0);
          m1_done <= (cur == M1);
          m0_err  <= (cur == M0) && !cur_valid;
          m1_err  <= (cur == M1) && !cur_valid;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  logic [31:0] ref_mem [0:63];
  logic [31:0] ref_rdata [0:1];
  logic        ref_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end

  dmem_arbiter #(.RAM_SIZE(256)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic ref_valid(input logic [31:0] a);
    return (a % 4 == 0) && (a < 256);
  endfunction

  function automatic logic ref_pick(input logic [1:0] mask);
    if (mask == 2'b01) return 1'b0;
    if (mask == 2'b10) return 1'b1;
    return !ref_last;
  endfunction

  function automatic void ref_apply(input logic m, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (ref_valid(a)) begin
      if (wr) ref_mem[a / 4] = d;
      else    ref_rdata[m] = ref_mem[a / 4];
    end
    ref_last = m;
  endfunction

  function automatic logic [31:0] rand_addr(input int kind);
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) * 4;
    case (kind)
      1: a = a + 32'($urandom_range(1, 3));
      2: a = 32'd256 + 32'($urandom_range(0, 255)) * 4;
      default: ;
    endcase
    return a;
  endfunction

  task automatic set_req(input logic m, input logic rq, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (!m) begin m0_req = rq; m0_wr = wr; m0_addr = a; m0_wdata = d; end
    else    begin m1_req = rq; m1_wr = wr; m1_addr = a; m1_wdata = d; end
  endtask

  // Observe one transaction of master m from the current negedge; cycle numbers count from here.
  task automatic wait_txn(input logic m, input logic hold, output int gc, output int dc,
                          output logic err, output logic rd_g, output logic wr_g, output logic other);
    gc = -1; dc = -1; err = 0; rd_g = 0; wr_g = 0; other = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (m ? (m0_gnt | m0_done | m0_err) : (m1_gnt | m1_done | m1_err)) other = 1;
      if (m0_gnt && m1_gnt) other = 1;
      if (m ? m1_gnt : m0_gnt) begin gc = k; rd_g = mem_rd; wr_g = mem_wr; end
      if ((m0_gnt || m1_gnt) && !hold) begin m0_req = 0; m1_req = 0; end
      if (m ? m1_done : m0_done) begin dc = k; err = m ? m1_err : m0_err; break; end
    end
  endtask

  task automatic test_reset;
    reset = 0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = (i == 4) ? 32'hCAFE0001 : (32'hA5A50000 ^ (32'(i) * 32'h01010101));
      pre_we = 1; pre_idx = 6'(i); pre_val = ref_mem[i];
      @(negedge clk);
    end
    pre_we = 0;
    ref_rdata[0] = 0; ref_rdata[1] = 0; ref_last = 1'b1;
    checks++;
    if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, mem_rd, mem_wr} !== 8'h00) begin
      errors++; $display("FAIL reset_pulses: got %b expected 00000000",
                         {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, mem_rd, mem_wr});
    end
    checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata);
    end
    reset = 1;
  endtask

  task automatic test_first_read;
    int gc, dc; logic err, rd, wr, oth;
    set_req(0, 1, 0, 32'h10, 32'h0);
    wait_txn(0, 0, gc, dc, err, rd, wr, oth);
    ref_apply(0, 0, 32'h10, 32'h0);
    checks++; if (gc !== 1) begin errors++; $display("FAIL first_gnt_cycle: got %0d expected 1", gc); end
    checks++; if (rd !== 1'b1 || wr !== 1'b0) begin errors++; $display("FAIL first_mem_rd: got rd=%b wr=%b expected rd=1 wr=0", rd, wr); end
    checks++; if (dc !== 2) begin errors++; $display("FAIL first_done_cycle: got %0d expected 2", dc); end
    checks++; if (m0_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL first_rdata: got %h expected cafe0001", m0_rdata); end
    checks++; if (err !== 1'b0 || oth !== 1'b0) begin errors++; $display("FAIL first_side: got err=%b other=%b expected 0/0", err, oth); end
  endtask

  task automatic test_write_then_read;
    int gc, dc; logic err, rd, wr, oth;
    set_req(1, 1, 1, 32'h20, 32'h12345678);
    wait_txn(1, 0, gc, dc, err, rd, wr, oth);
    ref_apply(1, 1, 32'h20, 32'h12345678);
    checks++; if (gc !== 1 || dc !== 2 || wr !== 1'b1 || rd !== 1'b0) begin
      errors++; $display("FAIL m1_write: got gnt=%0d done=%0d wr=%b rd=%b expected 1 2 1 0", gc, dc, wr, rd);
    end
    set_req(0, 1, 0, 32'h20, 32'h0);
    wait_txn(0, 0, gc, dc, err, rd, wr, oth);
    ref_apply(0, 0, 32'h20, 32'h0);
    checks++; if (m0_rdata !== 32'h12345678) begin errors++; $display("FAIL readback: got %h expected 12345678", m0_rdata); end
    checks++; if (m1_rdata !== ref_rdata[1]) begin errors++; $display("FAIL m1_rdata_held: got %h expected %h", m1_rdata, ref_rdata[1]); end
  endtask

  task automatic test_errors;
    logic [31:0] addrs [0:4];
    int gc, dc; logic err, rd, wr, oth;
    addrs = '{32'h102, 32'h100, 32'hFC, 32'hFFFFFFF0, 32'h3};
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1, 0, addrs[i], 32'h0);
      wait_txn(0, 0, gc, dc, err, rd, wr, oth);
      ref_apply(0, 0, addrs[i], 32'h0);
      checks++;
      if (dc !== 2 || err !== !ref_valid(addrs[i]) || rd !== ref_valid(addrs[i])) begin
        errors++; $display("FAIL err_case %h: got done=%0d err=%b rd=%b expected 2 %b %b",
                           addrs[i], dc, err, rd, !ref_valid(addrs[i]), ref_valid(addrs[i]));
      end
      checks++; if (m0_rdata !== ref_rdata[0]) begin errors++; $display("FAIL err_rdata %h: got %h expected %h", addrs[i], m0_rdata, ref_rdata[0]); end
    end
  endtask

  task automatic test_alternate;
    logic [31:0] fa [0:1];
    logic [31:0] fd [0:1];
    logic rearm [0:1];
    logic g, exp;
    int grants = 0, last_cyc = -1, cyc = 0;
    for (int m = 0; m < 2; m++) begin
      fa[m] = rand_addr(0); fd[m] = $urandom; rearm[m] = 0;
      set_req(1'(m), 1, 1, fa[m], fd[m]);
    end
    while (grants < 8 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (m0_gnt && m1_gnt) begin checks++; errors++; $display("FAIL alt_both_gnt: got 1 expected 0 at cycle %0d", cyc); end
      if (m0_gnt || m1_gnt) begin
        g = m1_gnt; exp = ref_pick(2'b11);
        checks++; if (g !== exp) begin errors++; $display("FAIL alt_order grant %0d: got m%0d expected m%0d", grants, g, exp); end
        if (last_cyc >= 0) begin
          checks++; if (cyc - last_cyc !== 2) begin errors++; $display("FAIL alt_spacing: got %0d expected 2", cyc - last_cyc); end
        end
        ref_apply(g, 1, fa[g], fd[g]);
        set_req(g, 0, 1, fa[g], fd[g]);
        rearm[g] = 1; last_cyc = cyc; grants++;
      end else begin
        for (int m = 0; m < 2; m++) if (rearm[m]) begin
          fa[m] = rand_addr(0); fd[m] = $urandom; rearm[m] = 0;
          set_req(1'(m), 1, 1, fa[m], fd[m]);
        end
      end
    end
    m0_req = 0; m1_req = 0;
    checks++; if (grants !== 8) begin errors++; $display("FAIL alt_grants: got %0d expected 8", grants); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    int gc, dc, bad; logic err, rd, wr, oth, exp;
    logic [1:0] mask;
    logic [31:0] a [0:1];
    logic [31:0] d [0:1];
    logic w [0:1];
    for (int r = 0; r < 40; r++) begin
      mask = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        a[m] = rand_addr($urandom_range(0, 3)); d[m] = $urandom; w[m] = 1'($urandom_range(0, 1));
        set_req(1'(m), mask[m], w[m], a[m], d[m]);
      end
      exp = ref_pick(mask);
      wait_txn(exp, 0, gc, dc, err, rd, wr, oth);
      ref_apply(exp, w[exp], a[exp], d[exp]);
      checks++;
      if (gc !== 1 || dc !== 2 || oth !== 1'b0 || err !== !ref_valid(a[exp]) ||
          rd !== (ref_valid(a[exp]) && !w[exp]) || wr !== (ref_valid(a[exp]) && w[exp])) begin
        errors++; $display("FAIL rand %0d m%0d: got gnt=%0d done=%0d oth=%b err=%b rd=%b wr=%b", r, exp, gc, dc, oth, err, rd, wr);
      end
      checks++;
      if (m0_rdata !== ref_rdata[0] || m1_rdata !== ref_rdata[1]) begin
        errors++; $display("FAIL rand_rdata %0d: got %h/%h expected %h/%h", r, m0_rdata, m1_rdata, ref_rdata[0], ref_rdata[1]);
      end
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL mem_contents: got %0d differing words expected 0", bad); end
  endtask

  task automatic test_reset_during_access;
    int gc, dc; logic err, rd, wr, oth; logic saw_done = 0;
    set_req(1, 1, 1, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b1 || mem_wr !== 1'b1) begin errors++; $display("FAIL abort_setup: got gnt=%b wr=%b expected 1 1", m1_gnt, mem_wr); end
    m1_req = 0;
    reset = 0;
    #1;
    checks++;
    if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, mem_rd, mem_wr} !== 8'h00 || m0_rdata !== 0 || m1_rdata !== 0) begin
      errors++; $display("FAIL abort_outputs: got %b rdata %h/%h expected all zero",
                         {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, mem_rd, mem_wr}, m0_rdata, m1_rdata);
    end
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (m1_done) saw_done = 1; end
    reset = 1;
    ref_rdata[0] = 0; ref_rdata[1] = 0; ref_last = 1'b1;
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_done: got 1 expected 0"); end
    checks++; if (mem[16] !== ref_mem[16]) begin errors++; $display("FAIL abort_mem: got %h expected %h", mem[16], ref_mem[16]); end
    set_req(0, 1, 0, 32'h8, 32'h0);
    set_req(1, 1, 0, 32'hC, 32'h0);
    wait_txn(ref_pick(2'b11), 0, gc, dc, err, rd, wr, oth);
    ref_apply(ref_pick(2'b11), 0, 32'h8, 32'h0);
    checks++; if (gc !== 1 || dc !== 2 || oth !== 1'b0) begin errors++; $display("FAIL abort_tie_m0: got gnt=%0d done=%0d other=%b expected 1 2 0", gc, dc, oth); end
    checks++; if (m0_rdata !== ref_rdata[0]) begin errors++; $display("FAIL abort_tie_rdata: got %h expected %h", m0_rdata, ref_rdata[0]); end
  endtask

  task automatic test_back_to_back;
    int gc, dc; logic err, rd, wr, oth;
    set_req(0, 1, 0, 32'h14, 32'h0);
    wait_txn(0, 1, gc, dc, err, rd, wr, oth);
    ref_apply(0, 0, 32'h14, 32'h0);
    checks++; if (gc !== 1 || dc !== 2 || m0_rdata !== ref_rdata[0]) begin
      errors++; $display("FAIL b2b_first: got gnt=%0d done=%0d rdata=%h expected 1 2 %h", gc, dc, m0_rdata, ref_rdata[0]);
    end
    m0_addr = 32'h18;
    wait_txn(0, 0, gc, dc, err, rd, wr, oth);
    ref_apply(0, 0, 32'h18, 32'h0);
    checks++; if (gc !== 1 || dc !== 2 || m0_rdata !== ref_rdata[0]) begin
      errors++; $display("FAIL b2b_second: got gnt=%0d done=%0d rdata=%h expected 1 2 %h", gc, dc, m0_rdata, ref_rdata[0]);
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_write_then_read();
    test_errors();
    test_alternate();
    test_random();
    test_reset_during_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
